// File: rtl/dff_arb_pkg.sv
// Shared types, defaults and the round-robin pick function for the dff share arbiter.
package dff_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ACK  = 2'd2
  } arb_state_t;

  localparam int unsigned DFF_ARB_N     = 4;
  localparam int unsigned DFF_ARB_W     = 8;
  localparam int unsigned DFF_ARB_NMAX  = 16;
  localparam int unsigned DFF_ARB_IDMAX = 4;

  // First set bit of req scanning ptr, ptr+1, ... modulo n; 0 when req is empty.
  function automatic logic [DFF_ARB_IDMAX-1:0] rr_pick(
    input logic [DFF_ARB_NMAX-1:0]  req,
    input logic [DFF_ARB_IDMAX-1:0] ptr,
    input int unsigned              n
  );
    logic [DFF_ARB_IDMAX-1:0] win;
    logic                     found;
    int unsigned              idx;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    if (n != 0) begin
      for (int unsigned k = 0; k < DFF_ARB_NMAX; k++) begin
        idx = (32'(ptr) + k) % n;
        if ((k < n) && !found && req[idx[DFF_ARB_IDMAX-1:0]]) begin
          win   = idx[DFF_ARB_IDMAX-1:0];
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/dff_rr_pick.sv
// Combinational round-robin priority encoder: req and rr_ptr in, winner index and any-request out.
module dff_rr_pick
  import dff_arb_pkg::*;
#(
  parameter int unsigned N   = DFF_ARB_N,
  parameter int unsigned IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] rr_ptr,
  output logic [IDW-1:0] winner,
  output logic           any
);

  logic [DFF_ARB_NMAX-1:0]  req_ext;
  logic [DFF_ARB_IDMAX-1:0] ptr_ext;
  logic [DFF_ARB_IDMAX-1:0] pick;

  always_comb begin
    req_ext          = '0;
    req_ext[N-1:0]   = req;
    ptr_ext          = '0;
    ptr_ext[IDW-1:0] = rr_ptr;
    pick             = rr_pick(req_ext, ptr_ext, N);
    winner           = IDW'(pick);
    any              = |req;
  end

endmodule

// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter sharing one W-bit register among N requesters (IDLE -> LOAD -> ACK).
// Optional DFF_ARB_LOCK_EN adds a lock input that chains ACK back into LOAD for the same owner.
module dff_share_arbiter
  import dff_arb_pkg::*;
#(
  parameter int unsigned N   = DFF_ARB_N,
  parameter int unsigned W   = DFF_ARB_W,
  parameter int unsigned IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wdata,
`ifdef DFF_ARB_LOCK_EN
  input  logic [N-1:0]   lock,
`endif
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   ack,
  output logic [W-1:0]   q,
  output logic           q_valid,
  output logic [IDW-1:0] owner,
  output logic           busy
);

  arb_state_t     state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] pick_win;
  logic           pick_any;
  logic [IDW-1:0] next_ptr;
  logic [W-1:0]   load_data;
  logic [N-1:0]   owner_onehot;
  logic [N-1:0]   win_onehot;

  dff_rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (pick_win),
    .any    (pick_any)
  );

  // Pointer moves to the slot after the owner, wrapping at N-1 (stays 0 for N=1).
  always_comb begin
    next_ptr     = (owner == IDW'(N - 1)) ? '0 : owner + IDW'(1);
    load_data    = wdata[32'(owner) * W +: W];
    owner_onehot = N'(1) << owner;
    win_onehot   = N'(1) << pick_win;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      gnt     <= '0;
      ack     <= '0;
      q       <= '0;
      q_valid <= 1'b0;
      owner   <= '0;
      busy    <= 1'b0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt   <= win_onehot;
            owner <= pick_win;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        // Data is captured regardless of whether req[owner] is still high.
        LOAD: begin
          q       <= load_data;
          q_valid <= 1'b1;
          ack     <= owner_onehot;
          state   <= ACK;
        end
        ACK: begin
`ifdef DFF_ARB_LOCK_EN
          if (lock[owner] && req[owner]) begin
            state <= LOAD;
          end else
`endif
          begin
            rr_ptr <= next_ptr;
            gnt    <= '0;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
